// File: rtl/inst_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch_pkg
// Brief    : Shared instruction-word type and width helpers for the fetch path.
// Revision : 1.0 - initial release
// ============================================================================
package inst_fetch_pkg;

  localparam int INST_W = 68;

  typedef logic [INST_W-1:0] inst_t;

  // Occupancy must represent 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/inst_queue_if.sv
`default_nettype none
// ============================================================================
// Module   : inst_queue_if
// Brief    : Fetch-side and decode-side handshake bundle of the instruction queue.
// Revision : 1.0 - initial release
// ============================================================================
interface inst_queue_if
  import inst_fetch_pkg::*;
#(
  parameter int DATA_W = INST_W,
  parameter int DEPTH  = 4
);

  localparam int c_cnt_w = cnt_w(DEPTH);

  logic               flush;
  logic               in_valid;
  logic               in_ready;
  logic [DATA_W-1:0]  in_data;
  logic               out_valid;
  logic               out_ready;
  logic [DATA_W-1:0]  out_data;
  logic [c_cnt_w-1:0] count;

  modport master (
    output flush, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, count
  );

  modport slave (
    input  flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, count
  );

endinterface
`default_nettype wire

// File: rtl/inst_queue_ptr.sv
`default_nettype none
// ============================================================================
// Module   : inst_queue_ptr
// Brief    : Wrap counter 0..DEPTH-1 with synchronous clear (clear wins).
// Revision : 1.0 - initial release
// ============================================================================
module inst_queue_ptr
  import inst_fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  wire logic                    clk,
  input  wire logic                    rst_n,
  input  wire logic                    i_inc,
  input  wire logic                    i_clr,
  output logic [ptr_w(DEPTH)-1:0]      o_ptr
);

  localparam int                 c_ptr_w = ptr_w(DEPTH);
  localparam logic [c_ptr_w-1:0] c_last  = c_ptr_w'(DEPTH - 1);

  logic [c_ptr_w-1:0] r_ptr;

  // Explicit compare so non-power-of-two depths wrap correctly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (i_clr) begin
      r_ptr <= '0;
    end else if (i_inc) begin
      r_ptr <= (r_ptr == c_last) ? '0 : r_ptr + c_ptr_w'(1);
    end
  end

  assign o_ptr = r_ptr;

endmodule
`default_nettype wire

// File: rtl/inst_queue.sv
`default_nettype none
// ============================================================================
// Module   : inst_queue
// Brief    : DEPTH-entry fetch-to-decode instruction FIFO with flush and occupancy.
//            Optional zero-latency empty bypass when INST_QUEUE_BYPASS_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module inst_queue
  import inst_fetch_pkg::*;
#(
  parameter int DATA_W = INST_W,
  parameter int DEPTH  = 4
) (
  input wire logic    clk,
  input wire logic    rst_n,
  inst_queue_if.slave q_if
);

  localparam int                 c_cnt_w = cnt_w(DEPTH);
  localparam int                 c_ptr_w = ptr_w(DEPTH);
  localparam logic [c_cnt_w-1:0] c_full  = c_cnt_w'(DEPTH);

  logic [DATA_W-1:0]  r_mem [DEPTH];
  logic [c_cnt_w-1:0] r_count;
  logic [c_ptr_w-1:0] w_rd_ptr;
  logic [c_ptr_w-1:0] w_wr_ptr;
  logic               w_not_empty;
  logic               w_in_ready;
  logic               w_push;
  logic               w_pop_mem;
  logic               w_pass;
  logic               w_write;
  logic               w_rd_inc;
  logic               w_out_valid;
  logic [DATA_W-1:0]  w_out_data;

  assign w_not_empty = (r_count != '0);
  assign w_in_ready  = (r_count != c_full) | q_if.out_ready;
  assign w_push      = q_if.in_valid & w_in_ready;
  assign w_pop_mem   = w_not_empty & q_if.out_ready;

`ifdef INST_QUEUE_BYPASS_EN
  logic w_byp;

  // An empty queue forwards fetch straight to decode; a consumed word is never stored.
  assign w_byp  = ~w_not_empty & ~q_if.flush;
  assign w_pass = w_byp & q_if.in_valid & q_if.out_ready;

  always_comb begin
    w_out_valid = w_not_empty;
    w_out_data  = w_not_empty ? r_mem[w_rd_ptr] : '0;
    if (w_byp) begin
      w_out_valid = q_if.in_valid;
      w_out_data  = q_if.in_valid ? q_if.in_data : '0;
    end
  end
`else
  assign w_pass      = 1'b0;
  assign w_out_valid = w_not_empty;
  assign w_out_data  = w_not_empty ? r_mem[w_rd_ptr] : '0;
`endif

  assign w_write  = w_push & ~w_pass & ~q_if.flush;
  assign w_rd_inc = w_pop_mem & ~q_if.flush;

  inst_queue_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (w_rd_inc),
    .i_clr (q_if.flush),
    .o_ptr (w_rd_ptr)
  );

  inst_queue_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (w_write),
    .i_clr (q_if.flush),
    .o_ptr (w_wr_ptr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (q_if.flush) begin
      r_count <= '0;
    end else if (w_write && !w_rd_inc) begin
      r_count <= r_count + c_cnt_w'(1);
    end else if (w_rd_inc && !w_write) begin
      r_count <= r_count - c_cnt_w'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_write) begin
      r_mem[w_wr_ptr] <= q_if.in_data;
    end
  end

  assign q_if.in_ready  = w_in_ready;
  assign q_if.out_valid = w_out_valid;
  assign q_if.out_data  = w_out_data;
  assign q_if.count     = r_count;

`ifdef SIM
  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(w_push && (r_count == c_full) && !w_pop_mem));
`endif

endmodule
`default_nettype wire

// File: tb/tb_inst_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_queue
// Brief    : Directed self-checking bench for inst_queue at DEPTH 4, 3 and 5.
// Revision : 1.0 - initial release
// ============================================================================
module tb_inst_queue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [67:0] in_data = '0;
  logic [67:0] e;
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  inst_queue_if #(.DATA_W(68), .DEPTH(4)) q4 ();
  inst_queue_if #(.DATA_W(68), .DEPTH(3)) q3 ();
  inst_queue_if #(.DATA_W(68), .DEPTH(5)) q5 ();

  assign q4.flush = flush;  assign q4.in_valid = in_valid;
  assign q4.in_data = in_data;  assign q4.out_ready = out_ready;
  assign q3.flush = flush;  assign q3.in_valid = in_valid;
  assign q3.in_data = in_data;  assign q3.out_ready = out_ready;
  assign q5.flush = flush;  assign q5.in_valid = in_valid;
  assign q5.in_data = in_data;  assign q5.out_ready = out_ready;

  inst_queue #(.DATA_W(68), .DEPTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .q_if(q4));
  inst_queue #(.DATA_W(68), .DEPTH(3)) dut3 (.clk(clk), .rst_n(rst_n), .q_if(q3));
  inst_queue #(.DATA_W(68), .DEPTH(5)) dut5 (.clk(clk), .rst_n(rst_n), .q_if(q5));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_vec++; if (q4.count !== 3'd0) begin n_err++; $display("FAIL rst_count got %0d exp 0", q4.count); end
    n_vec++; if (q4.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got %b exp 0", q4.out_valid); end
    n_vec++; if (q4.in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready got %b exp 1", q4.in_ready); end
    n_vec++; if (q4.out_data !== 68'h0) begin n_err++; $display("FAIL rst_out_data got %h exp 0", q4.out_data); end
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 68'h51 + 68'(i);
      step();
    end
    in_valid = 1'b0;
    #1;
    n_vec++; if (q4.count !== 3'd3) begin n_err++; $display("FAIL pre_rst_count got %0d exp 3", q4.count); end
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (q4.count !== 3'd0) begin n_err++; $display("FAIL async_rst_count got %0d exp 0", q4.count); end
    n_vec++; if (q4.out_valid !== 1'b0) begin n_err++; $display("FAIL async_rst_out_valid got %b exp 0", q4.out_valid); end
    n_vec++; if (q4.in_ready !== 1'b1) begin n_err++; $display("FAIL async_rst_in_ready got %b exp 1", q4.in_ready); end
    n_vec++; if (q4.out_data !== 68'h0) begin n_err++; $display("FAIL async_rst_out_data got %h exp 0", q4.out_data); end
    n_vec++; if (q5.count !== 3'd0) begin n_err++; $display("FAIL async_rst_count5 got %0d exp 0", q5.count); end
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_fill_drain();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 68'hA1 + 68'(i);
      step();
    end
    in_valid = 1'b0;
    #1;
    n_vec++; if (q4.count !== 3'd4) begin n_err++; $display("FAIL fill_count got %0d exp 4", q4.count); end
    n_vec++; if (q4.in_ready !== 1'b0) begin n_err++; $display("FAIL fill_in_ready got %b exp 0", q4.in_ready); end
    n_vec++; if (q3.count !== 2'd3) begin n_err++; $display("FAIL fill_count3 got %0d exp 3", q3.count); end
    n_vec++; if (q3.in_ready !== 1'b0) begin n_err++; $display("FAIL fill_in_ready3 got %b exp 0", q3.in_ready); end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      e = 68'hA1 + 68'(i);
      n_vec++; if (q4.out_data !== e) begin n_err++; $display("FAIL drain_data[%0d] got %h exp %h", i, q4.out_data, e); end
      n_vec++; if (q4.count !== 3'(4 - i)) begin n_err++; $display("FAIL drain_count[%0d] got %0d exp %0d", i, q4.count, 4 - i); end
      step();
    end
    out_ready = 1'b0;
    #1;
    n_vec++; if (q4.count !== 3'd0) begin n_err++; $display("FAIL drained_count got %0d exp 0", q4.count); end
    n_vec++; if (q4.out_valid !== 1'b0) begin n_err++; $display("FAIL drained_out_valid got %b exp 0", q4.out_valid); end
    n_vec++; if (q4.out_data !== 68'h0) begin n_err++; $display("FAIL drained_out_data got %h exp 0", q4.out_data); end
  endtask

  task automatic test_full_simul();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 68'hA1 + 68'(i);
      step();
    end
    in_data = 68'hB5; out_ready = 1'b1;
    #1;
    n_vec++; if (q4.in_ready !== 1'b1) begin n_err++; $display("FAIL full_in_ready got %b exp 1", q4.in_ready); end
    n_vec++; if (q4.out_data !== 68'hA1) begin n_err++; $display("FAIL full_head got %h exp a1", q4.out_data); end
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    n_vec++; if (q4.count !== 3'd4) begin n_err++; $display("FAIL full_simul_count got %0d exp 4", q4.count); end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      e = (i == 3) ? 68'hB5 : 68'hA2 + 68'(i);
      n_vec++; if (q4.out_data !== e) begin n_err++; $display("FAIL full_order[%0d] got %h exp %h", i, q4.out_data, e); end
      step();
    end
    out_ready = 1'b0;
    #1;
    n_vec++; if (q4.count !== 3'd0) begin n_err++; $display("FAIL full_end_count got %0d exp 0", q4.count); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 68'hC1 + 68'(i);
      step();
    end
    flush = 1'b1; in_data = 68'hC0;
    #1;
    n_vec++; if (q4.in_ready !== 1'b1) begin n_err++; $display("FAIL flush_in_ready got %b exp 1", q4.in_ready); end
    step();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    n_vec++; if (q4.count !== 3'd0) begin n_err++; $display("FAIL flush_count got %0d exp 0", q4.count); end
    n_vec++; if (q4.out_valid !== 1'b0) begin n_err++; $display("FAIL flush_out_valid got %b exp 0", q4.out_valid); end
    n_vec++; if (q4.out_data !== 68'h0) begin n_err++; $display("FAIL flush_out_data got %h exp 0", q4.out_data); end
    in_valid = 1'b1; in_data = 68'hE1;
    step();
    in_valid = 1'b0;
    #1;
    n_vec++; if (q4.out_data !== 68'hE1) begin n_err++; $display("FAIL post_flush_head got %h exp e1", q4.out_data); end
    n_vec++; if (q4.count !== 3'd1) begin n_err++; $display("FAIL post_flush_count got %0d exp 1", q4.count); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_wrap();
    flush = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    step();
    flush = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = 68'h10 + 68'(i);
      step();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_data = 68'h12 + 68'(i);
      #1;
      e = 68'h10 + 68'(i);
      n_vec++; if (q4.out_data !== e) begin n_err++; $display("FAIL wrap4[%0d] got %h exp %h", i, q4.out_data, e); end
      n_vec++; if (q3.out_data !== e) begin n_err++; $display("FAIL wrap3[%0d] got %h exp %h", i, q3.out_data, e); end
      n_vec++; if (q5.out_data !== e) begin n_err++; $display("FAIL wrap5[%0d] got %h exp %h", i, q5.out_data, e); end
      n_vec++; if (q3.count !== 2'd2) begin n_err++; $display("FAIL wrap3_count[%0d] got %0d exp 2", i, q3.count); end
      step();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      e = 68'h1A + 68'(i);
      n_vec++; if (q5.out_data !== e) begin n_err++; $display("FAIL wrap_tail5[%0d] got %h exp %h", i, q5.out_data, e); end
      n_vec++; if (q3.out_data !== e) begin n_err++; $display("FAIL wrap_tail3[%0d] got %h exp %h", i, q3.out_data, e); end
      step();
    end
    out_ready = 1'b0;
    #1;
    n_vec++; if (q4.count !== 3'd0) begin n_err++; $display("FAIL wrap_end_count got %0d exp 0", q4.count); end
  endtask

  task automatic test_bypass();
    in_valid = 1'b1; in_data = 68'hD7; out_ready = 1'b1;
    #1;
`ifdef INST_QUEUE_BYPASS_EN
    n_vec++; if (q4.out_valid !== 1'b1) begin n_err++; $display("FAIL byp_out_valid got %b exp 1", q4.out_valid); end
    n_vec++; if (q4.out_data !== 68'hD7) begin n_err++; $display("FAIL byp_out_data got %h exp d7", q4.out_data); end
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    n_vec++; if (q4.count !== 3'd0) begin n_err++; $display("FAIL byp_count got %0d exp 0", q4.count); end
    n_vec++; if (q4.out_valid !== 1'b0) begin n_err++; $display("FAIL byp_after_valid got %b exp 0", q4.out_valid); end
`else
    n_vec++; if (q4.out_valid !== 1'b0) begin n_err++; $display("FAIL nobyp_out_valid got %b exp 0", q4.out_valid); end
    n_vec++; if (q4.out_data !== 68'h0) begin n_err++; $display("FAIL nobyp_out_data got %h exp 0", q4.out_data); end
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    n_vec++; if (q4.out_valid !== 1'b1) begin n_err++; $display("FAIL nobyp_next_valid got %b exp 1", q4.out_valid); end
    n_vec++; if (q4.out_data !== 68'hD7) begin n_err++; $display("FAIL nobyp_next_data got %h exp d7", q4.out_data); end
    n_vec++; if (q4.count !== 3'd1) begin n_err++; $display("FAIL nobyp_count got %0d exp 1", q4.count); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
`endif
  endtask

  initial begin
    step();
    step();
    rst_n = 1'b1;
    step();
    test_reset();
    test_fill_drain();
    test_full_simul();
    test_flush();
    test_wrap();
    test_bypass();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
